// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Purpose : Bundles the pipeline-status inputs and the sequencing/counter
//           outputs of hazard_ctrl so the core and the controller share one
//           connection point.
// Signals :
//   ID_Rs, ID_Rt (5)          source register numbers of the ID instruction
//   ID_UseRs, ID_UseRt        ID instruction actually reads rs / rt
//   ID_Jump, ID_Syscall       jump / syscall decoded in ID
//   EX_WbRegNum (5)           destination of the EX instruction
//   EX_RegWrite, EX_MemtoReg  EX writes a register / EX is a load
//   EX_BranchTaken            branch resolved taken in EX
//   MEM_WbRegNum (5)          destination of the MEM instruction
//   MEM_RegWrite              MEM writes a register
//   Go                        resume pulse (only meaningful while halted)
//   PC_EN, EN1..EN4           PC and pipeline register enables
//   Flush1, Flush2            bubble insertion into IF/ID and ID/EX
//   Halted                    controller is in HALT
//   CycleCnt, StallCnt, FlushCnt (CNT_W) performance counters
// Modports: master = pipeline side (drives status), slave = controller.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       ID_Rs;
   logic [4:0]       ID_Rt;
   logic             ID_UseRs;
   logic             ID_UseRt;
   logic             ID_Jump;
   logic             ID_Syscall;
   logic [4:0]       EX_WbRegNum;
   logic             EX_RegWrite;
   logic             EX_MemtoReg;
   logic             EX_BranchTaken;
   logic [4:0]       MEM_WbRegNum;
   logic             MEM_RegWrite;
   logic             Go;

   logic             PC_EN;
   logic             EN1;
   logic             EN2;
   logic             EN3;
   logic             EN4;
   logic             Flush1;
   logic             Flush2;
   logic             Halted;
   logic [CNT_W-1:0] CycleCnt;
   logic [CNT_W-1:0] StallCnt;
   logic [CNT_W-1:0] FlushCnt;

   modport master (
      output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Jump, ID_Syscall,
             EX_WbRegNum, EX_RegWrite, EX_MemtoReg, EX_BranchTaken,
             MEM_WbRegNum, MEM_RegWrite, Go,
      input  PC_EN, EN1, EN2, EN3, EN4, Flush1, Flush2, Halted,
             CycleCnt, StallCnt, FlushCnt
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Jump, ID_Syscall,
             EX_WbRegNum, EX_RegWrite, EX_MemtoReg, EX_BranchTaken,
             MEM_WbRegNum, MEM_RegWrite, Go,
      output PC_EN, EN1, EN2, EN3, EN4, Flush1, Flush2, Halted,
             CycleCnt, StallCnt, FlushCnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Purpose : Sequencing controller for the five-stage MIPS pipeline. Detects
//           RAW / load-use hazards, inserts bubbles on taken branches and
//           jumps, drains and halts the pipe on SYSCALL, and keeps cycle,
//           stall and redirect counters.
// Ports   :
//   clk  system clock
//   CLR  synchronous active-high reset
//   bus  hazard_ctrl_if.slave (pipeline status in, enables/flushes/counters out)
// Parameters:
//   FORWARDING   0: stall on any RAW vs EX or MEM; 1: stall only on load-use in EX
//   DRAIN_CYCLES cycles for a SYSCALL to travel from EX to WB
//   CNT_W        performance counter width
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int FORWARDING   = 0,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input logic          clk,
   input logic          CLR,
   hazard_ctrl_if.slave bus
);
   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [DW-1:0]    r_drain;
   logic [DW-1:0]    w_drain_nxt;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
   logic w_stall;
   logic w_inc_stall, w_inc_flush;
   logic w_pc_en, w_en1, w_en2, w_en3, w_en4, w_flush1, w_flush2;

   // $0 is hard-wired, so a zero register number never creates a dependency
   assign w_rs_ex  = bus.ID_UseRs && (bus.ID_Rs != 5'd0) && bus.EX_RegWrite  && (bus.ID_Rs == bus.EX_WbRegNum);
   assign w_rt_ex  = bus.ID_UseRt && (bus.ID_Rt != 5'd0) && bus.EX_RegWrite  && (bus.ID_Rt == bus.EX_WbRegNum);
   assign w_rs_mem = bus.ID_UseRs && (bus.ID_Rs != 5'd0) && bus.MEM_RegWrite && (bus.ID_Rs == bus.MEM_WbRegNum);
   assign w_rt_mem = bus.ID_UseRt && (bus.ID_Rt != 5'd0) && bus.MEM_RegWrite && (bus.ID_Rt == bus.MEM_WbRegNum);

   // With bypassing, only a load in EX cannot be forwarded in time
   assign w_stall = (FORWARDING != 0) ? (bus.EX_MemtoReg && (w_rs_ex || w_rt_ex))
                                      : (w_rs_ex || w_rt_ex || w_rs_mem || w_rt_mem);

   always_comb begin
      w_next      = r_state;
      w_drain_nxt = r_drain;
      w_pc_en     = 1'b1;
      w_en1       = 1'b1;
      w_en2       = 1'b1;
      w_en3       = 1'b1;
      w_en4       = 1'b1;
      w_flush1    = 1'b0;
      w_flush2    = 1'b0;
      w_inc_stall = 1'b0;
      w_inc_flush = 1'b0;
      case (r_state)
         S_RUN: begin
            if (bus.EX_BranchTaken) begin
               // Wrong-path instructions sit in IF/ID and ID/EX
               w_flush1    = 1'b1;
               w_flush2    = 1'b1;
               w_inc_flush = 1'b1;
            end else if (w_stall) begin
               // Hold PC and IF/ID so the ID instruction (jump/syscall too) retries
               w_pc_en     = 1'b0;
               w_en1       = 1'b0;
               w_flush2    = 1'b1;
               w_inc_stall = 1'b1;
            end else if (bus.ID_Syscall) begin
               // Syscall moves to EX; PC held at SYSCALL+4 for the resume
               w_pc_en     = 1'b0;
               w_flush1    = 1'b1;
               w_next      = S_DRAIN;
               w_drain_nxt = DW'(DRAIN_CYCLES);
            end else if (bus.ID_Jump) begin
               w_flush1    = 1'b1;
               w_inc_flush = 1'b1;
            end
         end
         S_DRAIN: begin
            w_pc_en     = 1'b0;
            w_en1       = 1'b0;
            w_flush2    = 1'b1;
            w_drain_nxt = r_drain - DW'(1);
            if (r_drain <= DW'(1)) begin
               w_next = S_HALT;
            end
         end
         S_HALT: begin
            w_pc_en = 1'b0;
            w_en1   = 1'b0;
            w_en2   = 1'b0;
            w_en3   = 1'b0;
            w_en4   = 1'b0;
            if (bus.Go) begin
               w_next = S_RUN;
            end
         end
         default: begin
            w_next = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (CLR) begin
         r_state     <= S_RUN;
         r_drain     <= '0;
         r_cyc_cnt   <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_drain <= w_drain_nxt;
         if (r_state != S_HALT) begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
         end
         if (w_inc_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_inc_flush) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.PC_EN    = w_pc_en;
   assign bus.EN1      = w_en1;
   assign bus.EN2      = w_en2;
   assign bus.EN3      = w_en3;
   assign bus.EN4      = w_en4;
   assign bus.Flush1   = w_flush1;
   assign bus.Flush2   = w_flush2;
   assign bus.Halted   = (r_state == S_HALT);
   assign bus.CycleCnt = r_cyc_cnt;
   assign bus.StallCnt = r_stall_cnt;
   assign bus.FlushCnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Purpose : Self-checking bench for hazard_ctrl. Two instances run side by
//           side: dut0 without forwarding, dut1 with forwarding. Each cycle the
//           expected control vector {PC_EN,EN1..EN4,Flush1,Flush2,Halted} of
//           both instances is queued when stimulus is applied and compared on
//           the following falling edge; counters are checked directly.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
   localparam logic [7:0] NORM = 8'b1111_1000;
   localparam logic [7:0] STAL = 8'b0011_1010;
   localparam logic [7:0] BRAN = 8'b1111_1110;
   localparam logic [7:0] SYSC = 8'b0111_1100;
   localparam logic [7:0] JUMP = 8'b1111_1100;
   localparam logic [7:0] DRN  = 8'b0011_1010;
   localparam logic [7:0] HLT  = 8'b0000_0001;

   logic clk = 1'b0;
   logic CLR = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(32)) bus0 ();
   hazard_ctrl_if #(.CNT_W(32)) bus1 ();

   hazard_ctrl #(.FORWARDING(0), .DRAIN_CYCLES(3), .CNT_W(32)) dut0 (
      .clk(clk), .CLR(CLR), .bus(bus0)
   );
   hazard_ctrl #(.FORWARDING(1), .DRAIN_CYCLES(3), .CNT_W(32)) dut1 (
      .clk(clk), .CLR(CLR), .bus(bus1)
   );

   int n_cmp = 0;
   int n_err = 0;

   string       tq[$];
   logic [15:0] eq[$];
   string       mon_tag;
   logic [15:0] mon_exp;

   wire [7:0] ctrl0 = {bus0.PC_EN, bus0.EN1, bus0.EN2, bus0.EN3, bus0.EN4,
                       bus0.Flush1, bus0.Flush2, bus0.Halted};
   wire [7:0] ctrl1 = {bus1.PC_EN, bus1.EN1, bus1.EN2, bus1.EN3, bus1.EN4,
                       bus1.Flush1, bus1.Flush2, bus1.Halted};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: outputs are combinational, sampled mid-cycle
   always @(negedge clk) begin
      if (eq.size() > 0) begin
         mon_exp = eq.pop_front();
         mon_tag = tq.pop_front();
         check_val({mon_tag, "/f0"}, {56'd0, ctrl0}, {56'd0, mon_exp[15:8]});
         check_val({mon_tag, "/f1"}, {56'd0, ctrl1}, {56'd0, mon_exp[7:0]});
      end
   end

   task automatic idle();
      bus0.ID_Rs = 5'd0; bus0.ID_Rt = 5'd0; bus0.ID_UseRs = 1'b0; bus0.ID_UseRt = 1'b0;
      bus0.ID_Jump = 1'b0; bus0.ID_Syscall = 1'b0; bus0.EX_WbRegNum = 5'd0;
      bus0.EX_RegWrite = 1'b0; bus0.EX_MemtoReg = 1'b0; bus0.EX_BranchTaken = 1'b0;
      bus0.MEM_WbRegNum = 5'd0; bus0.MEM_RegWrite = 1'b0; bus0.Go = 1'b0;
      bus1.ID_Rs = 5'd0; bus1.ID_Rt = 5'd0; bus1.ID_UseRs = 1'b0; bus1.ID_UseRt = 1'b0;
      bus1.ID_Jump = 1'b0; bus1.ID_Syscall = 1'b0; bus1.EX_WbRegNum = 5'd0;
      bus1.EX_RegWrite = 1'b0; bus1.EX_MemtoReg = 1'b0; bus1.EX_BranchTaken = 1'b0;
      bus1.MEM_WbRegNum = 5'd0; bus1.MEM_RegWrite = 1'b0; bus1.Go = 1'b0;
   endtask

   // Queue expectations for the inputs just applied, then advance one cycle
   task automatic step(input string tag, input logic [7:0] e0, input logic [7:0] e1);
      tq.push_back(tag);
      eq.push_back({e0, e1});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int c0, input int s0, input int f0, input int c1, input int s1);
      check_val({tag, "/cyc0"},   64'(bus0.CycleCnt), 64'(c0));
      check_val({tag, "/stall0"}, 64'(bus0.StallCnt), 64'(s0));
      check_val({tag, "/flush0"}, 64'(bus0.FlushCnt), 64'(f0));
      check_val({tag, "/cyc1"},   64'(bus1.CycleCnt), 64'(c1));
      check_val({tag, "/stall1"}, 64'(bus1.StallCnt), 64'(s1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      CLR = 1'b0;
      chk_cnt("reset", 0, 0, 0, 0, 0);
      step("reset_out", NORM, NORM);

      // No forwarding: RAW against EX, then against MEM
      idle();
      bus0.EX_RegWrite = 1'b1; bus0.EX_WbRegNum = 5'd5; bus0.ID_UseRs = 1'b1; bus0.ID_Rs = 5'd5;
      step("raw_ex", STAL, NORM);
      idle();
      bus0.MEM_RegWrite = 1'b1; bus0.MEM_WbRegNum = 5'd5; bus0.ID_UseRs = 1'b1; bus0.ID_Rs = 5'd5;
      step("raw_mem", STAL, NORM);
      chk_cnt("raw2", 3, 2, 0, 3, 0);
      idle();
      bus0.EX_RegWrite = 1'b1; bus0.EX_WbRegNum = 5'd0; bus0.ID_UseRs = 1'b1; bus0.ID_Rs = 5'd0;
      step("reg0", NORM, NORM);
      idle();
      bus0.EX_RegWrite = 1'b1; bus0.EX_WbRegNum = 5'd7; bus0.ID_UseRt = 1'b0; bus0.ID_Rt = 5'd7;
      step("nouse", NORM, NORM);
      chk_cnt("nostall", 5, 2, 0, 5, 0);

      // Forwarding: only load-use in EX stalls
      idle();
      bus1.EX_RegWrite = 1'b1; bus1.EX_MemtoReg = 1'b1; bus1.EX_WbRegNum = 5'd8;
      bus1.ID_UseRt = 1'b1; bus1.ID_Rt = 5'd8;
      step("ldu_ex", NORM, STAL);
      idle();
      bus1.MEM_RegWrite = 1'b1; bus1.MEM_WbRegNum = 5'd8; bus1.ID_UseRt = 1'b1; bus1.ID_Rt = 5'd8;
      step("ldu_mem", NORM, NORM);
      idle();
      bus1.EX_RegWrite = 1'b1; bus1.EX_WbRegNum = 5'd8; bus1.ID_UseRt = 1'b1; bus1.ID_Rt = 5'd8;
      step("alu_fwd", NORM, NORM);
      chk_cnt("fwd", 8, 2, 0, 8, 1);

      // Branch beats stall and jump; then jump alone; then stall holds a jump
      idle();
      bus0.EX_BranchTaken = 1'b1; bus0.ID_Jump = 1'b1;
      bus0.EX_RegWrite = 1'b1; bus0.EX_WbRegNum = 5'd5; bus0.ID_UseRs = 1'b1; bus0.ID_Rs = 5'd5;
      step("br_prio", BRAN, NORM);
      chk_cnt("br", 9, 2, 1, 9, 1);
      idle();
      bus0.ID_Jump = 1'b1;
      step("jump", JUMP, NORM);
      idle();
      bus0.ID_Jump = 1'b1;
      bus0.EX_RegWrite = 1'b1; bus0.EX_WbRegNum = 5'd9; bus0.ID_UseRt = 1'b1; bus0.ID_Rt = 5'd9;
      step("jmp_held", STAL, NORM);
      chk_cnt("jmp", 11, 3, 2, 11, 1);

      // Syscall (with a jump alongside) -> 3 drain cycles -> halt
      idle();
      bus0.ID_Syscall = 1'b1; bus0.ID_Jump = 1'b1;
      step("sys_issue", SYSC, NORM);
      idle();
      bus0.EX_BranchTaken = 1'b1; bus0.ID_Jump = 1'b1;
      bus0.EX_RegWrite = 1'b1; bus0.EX_WbRegNum = 5'd5; bus0.ID_UseRs = 1'b1; bus0.ID_Rs = 5'd5;
      step("drain1", DRN, NORM);
      idle();
      bus0.Go = 1'b1;
      step("drain2", DRN, NORM);
      idle();
      step("drain3", DRN, NORM);
      chk_cnt("drained", 15, 3, 2, 15, 1);
      for (int i = 0; i < 10; i++) step("halt", HLT, NORM);
      chk_cnt("halted", 15, 3, 2, 25, 1);
      bus0.Go = 1'b1;
      step("go", HLT, NORM);
      idle();
      step("resume", NORM, NORM);
      chk_cnt("resumed", 16, 3, 2, 27, 1);

      // Reset in the middle of a drain
      idle();
      bus0.ID_Syscall = 1'b1;
      step("sys2", SYSC, NORM);
      idle();
      step("drain_a", DRN, NORM);
      CLR = 1'b1;
      step("drain_b", DRN, NORM);
      CLR = 1'b0;
      chk_cnt("clr_drain", 0, 0, 0, 0, 0);
      step("post_clr", NORM, NORM);
      chk_cnt("post_clr", 1, 0, 0, 1, 0);

      @(negedge clk);
      check_val("sb_empty", 64'(eq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
